// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step per clock.
// The engine runs IDLE -> CALC (WIDTH steps) -> FIX (sign correction, one-cycle done pulse).
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_high,
    output logic [WIDTH-1:0] out_low,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] residue,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               op_div_q, op_div_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, quo_q, quo_d, res_q, res_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     msum, rem_sh, dsub;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    // acc holds {upper accumulator, multiplier} for mul and {remainder, quotient} for div
    always_comb begin
        a_mag    = (sign && A[WIDTH-1]) ? -A : A;
        b_mag    = (sign && B[WIDTH-1]) ? -B : B;
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {msum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dsub     = rem_sh - {1'b0, opnd_q};
        div_next = dsub[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {dsub[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
        prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        op_div_d = op_div_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        quo_d    = quo_q;
        res_d    = res_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    opnd_d   = op_div ? b_mag : a_mag;
                    a_raw_d  = A;
                    a_neg_d  = sign & A[WIDTH-1];
                    b_neg_d  = sign & B[WIDTH-1];
                    op_div_d = op_div;
                    b_zero_d = (B == '0);
                    dbz_d    = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d = op_div_q ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!op_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_zero_q) begin
                    quo_d = '1;
                    res_d = a_raw_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    res_d = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            op_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            op_div_q <= op_div_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            quo_q    <= quo_d;
            res_q    <= res_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign out_high    = hi_q;
    assign out_low     = lo_q;
    assign quotient    = quo_q;
    assign residue     = res_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] out_high, out_low, quotient, residue;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_hi = '0, exp_lo = '0, exp_q = '0, exp_r = '0;
    logic        exp_dbz = 1'b0;

    bit          pending = 1'b0;
    bit          n_div, n_sgn;
    logic [31:0] n_a, n_b;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .sign(sign),
        .A(A), .B(B), .busy(busy), .done(done), .out_high(out_high), .out_low(out_low),
        .quotient(quotient), .residue(residue), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        exp_dbz = div && (b == 0);
        if (!div) begin
            p = 64'(sa * sb);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == 0) begin
            exp_q = 32'hFFFF_FFFF;
            exp_r = a;
        end else begin
            exp_q = 32'(sa / sb);
            exp_r = 32'(sa % sb);
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".hi"},  out_high,    exp_hi);
        chk({tag, ".lo"},  out_low,     exp_lo);
        chk({tag, ".q"},   quotient,    exp_q);
        chk({tag, ".r"},   residue,     exp_r);
        chk({tag, ".dbz"}, div_by_zero, exp_dbz);
    endtask

    // inj > 0 pulses a junk start that many cycles into the operation; chain launches n_* on the done cycle
    task automatic run_op(input string tag, input bit div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inj, input bit chain);
        int lat, busy_cnt;
        if (!pending) begin
            @(negedge clk);
            start = 1'b1; op_div = div; sign = sgn; A = a; B = b;
        end
        pending = 1'b0;
        model(div, sgn, a, b);
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; op_div = $urandom_range(0, 1); sign = $urandom_range(0, 1);
        chk({tag, ".dbz_clr"}, div_by_zero, 1'b0);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            start = (inj > 0 && lat == inj);
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
        end
        chk({tag, ".lat"}, lat, 33);
        chk({tag, ".busy_cyc"}, busy_cnt, 33);
        check_outputs(tag);
        if (chain) begin
            start = 1'b1; op_div = n_div; sign = n_sgn; A = n_a; B = n_b;
            pending = 1'b1;
        end else begin
            @(posedge clk); #1;
            chk({tag, ".done_pulse"}, done, 1'b0);
            chk({tag, ".idle"}, busy, 1'b0);
        end
    endtask

    initial begin
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        check_outputs("rst");
        @(negedge clk); rst_n = 1'b1;

        run_op("umul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        chk("umul_max.hi_lit", out_high, 32'hFFFF_FFFE);
        chk("umul_max.lo_lit", out_low, 32'h0000_0001);
        run_op("smul", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0);
        chk("smul.lo_lit", out_low, 32'hFFFF_FFEB);
        run_op("udiv", 1'b1, 1'b0, 32'd100, 32'd7, 0, 1'b0);
        chk("udiv.q_lit", quotient, 32'd14);
        run_op("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        chk("sdiv.r_lit", residue, 32'hFFFF_FFFF);
        run_op("div0", 1'b1, 1'b0, 32'd5, 32'd0, 0, 1'b0);
        chk("div0.flag_lit", div_by_zero, 1'b1);
        run_op("ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        chk("ovf.q_lit", quotient, 32'h8000_0000);
        run_op("sdiv0", 1'b1, 1'b1, 32'hFFFF_FF00, 32'd0, 0, 1'b0);

        n_div = 1'b0; n_sgn = 1'b1; n_a = 32'h8000_0000; n_b = 32'h8000_0000;
        run_op("b2b_a", 1'b1, 1'b0, 32'd1000, 32'd33, 0, 1'b1);
        run_op("b2b_b", n_div, n_sgn, n_a, n_b, 0, 1'b0);

        run_op("busy_ign", 1'b0, 1'b0, 32'd12345, 32'd678, 5, 1'b0);

        @(negedge clk);
        start = 1'b1; op_div = 1'b0; sign = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0; exp_q = '0; exp_r = '0; exp_dbz = 1'b0;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.done", done, 1'b0);
        check_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        run_op("post_rst", 1'b0, 1'b0, 32'd6, 32'd7, 0, 1'b0);
        chk("post_rst.lo_lit", out_low, 32'd42);

        for (int i = 0; i < 40; i++) begin
            bit          d, s;
            logic [31:0] a, b;
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 7 == 0) b = '0;
            else if (i % 3 == 0) b = 32'($signed($urandom_range(0, 31)) - 16);
            if (i % 11 == 5) a = 32'h8000_0000;
            run_op("rand", d, s, a, b, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
